// File: rtl/cache_arbiter_n.sv
// N-channel arbiter between L1 requestors and a single L2 port.
// The grant is registered, and a SETTLE cycle separates each grant change from the first L2 strobe.
module cache_arbiter_n #(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 128,
   parameter int RR_MODE = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*ADDR_W-1:0] ch_address_in,
   input  logic [NUM_CH*DATA_W-1:0] ch_wdata_in,
   input  logic [NUM_CH-1:0]        ch_read_in,
   input  logic [NUM_CH-1:0]        ch_write_in,
   output logic [NUM_CH-1:0]        ch_resp_out,
   output logic [DATA_W-1:0]        ch_rdata_out,
   output logic [ADDR_W-1:0]        s_address_out,
   output logic [DATA_W-1:0]        s_wdata_out,
   output logic                     s_read_out,
   output logic                     s_write_out,
   input  logic [DATA_W-1:0]        s_rdata_in,
   input  logic                     s_resp_in,
   output logic [NUM_CH-1:0]        grant_out,
   output logic                     busy_out,
   output logic [1:0]               state_out
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   state_t             r_state;
   logic [NUM_CH-1:0]  r_grant;
   logic [IDX_W-1:0]   r_gidx;
   logic [IDX_W-1:0]   r_last;

   logic [NUM_CH-1:0]  w_req;
   logic               w_any;
   logic [IDX_W-1:0]   w_cand;
   logic [IDX_W-1:0]   w_win;
   logic [NUM_CH-1:0]  w_win_oh;
   logic [ADDR_W-1:0]  w_sel_addr;
   logic [DATA_W-1:0]  w_sel_wdata;

   // Both searches scan from lowest to highest priority so the last hit is the winner.
   // Round-robin starts after r_last with an explicit modulo, so non-power-of-two counts wrap correctly.
   always_comb begin
      w_req    = ch_read_in | ch_write_in;
      w_any    = |w_req;
      w_cand   = '0;
      w_win    = '0;
      w_win_oh = '0;
      if (RR_MODE != 0) begin
         for (int k = NUM_CH; k >= 1; k--) begin
            w_cand = IDX_W'((int'(r_last) + k) % NUM_CH);
            if (w_req[w_cand]) w_win = w_cand;
         end
      end else begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_cand = IDX_W'(i);
            if (w_req[w_cand]) w_win = w_cand;
         end
      end
      w_win_oh[w_win] = 1'b1;
   end

   assign w_sel_addr  = ch_address_in[int'(r_gidx)*ADDR_W +: ADDR_W];
   assign w_sel_wdata = ch_wdata_in[int'(r_gidx)*DATA_W +: DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_gidx  <= '0;
         r_last  <= IDX_W'(NUM_CH - 1);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_grant <= w_win_oh;
                  r_gidx  <= w_win;
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: r_state <= ST_ACTIVE;
            ST_ACTIVE: begin
               if (s_resp_in) begin
                  r_grant <= '0;
                  r_last  <= r_gidx;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_grant <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Address and data are presented during SETTLE, while strobes wait for ACTIVE.
   assign s_address_out = (r_state == ST_IDLE) ? '0 : w_sel_addr;
   assign s_wdata_out   = (r_state == ST_IDLE) ? '0 : w_sel_wdata;
   assign s_read_out    = (r_state == ST_ACTIVE) & ch_read_in[r_gidx];
   assign s_write_out   = (r_state == ST_ACTIVE) & ch_write_in[r_gidx];
   assign ch_resp_out   = (r_state == ST_ACTIVE) ? (r_grant & {NUM_CH{s_resp_in}}) : '0;
   assign ch_rdata_out  = s_rdata_in;
   assign grant_out     = r_grant;
   assign busy_out      = (r_state != ST_IDLE);
   assign state_out     = r_state;

endmodule

// File: tb/tb_cache_arbiter_n.sv
// Bench for cache_arbiter_n: a round-robin and a fixed-priority instance share one stimulus table,
// plus a hand-written asynchronous reset pulse in the middle of a transaction.
module tb_cache_arbiter_n;

   localparam int NCH = 3;
   localparam int AW  = 16;
   localparam int DW  = 128;
   localparam logic [1:0] I = 2'd0, S = 2'd1, A = 2'd2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NCH*AW-1:0] ch_address_in;
   logic [NCH*DW-1:0] ch_wdata_in;
   logic [NCH-1:0]    ch_read_in = '0;
   logic [NCH-1:0]    ch_write_in = '0;
   logic [DW-1:0]     s_rdata_in = '0;
   logic              s_resp_in = 1'b0;

   logic [NCH-1:0] rr_resp, fp_resp, rr_grant, fp_grant;
   logic [DW-1:0]  rr_rdata, fp_rdata, rr_wdata, fp_wdata;
   logic [AW-1:0]  rr_addr, fp_addr;
   logic           rr_rd, fp_rd, rr_wr, fp_wr, rr_busy, fp_busy;
   logic [1:0]     rr_state, fp_state;

   logic [AW-1:0] addr_tab [NCH];
   logic [DW-1:0] wd_tab [NCH];

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic           rst;
      logic [NCH-1:0] rd;
      logic [NCH-1:0] wr;
      logic           resp;
      logic [1:0]     st;
      logic [NCH-1:0] g_rr;
      logic [NCH-1:0] g_fp;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   cache_arbiter_n #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .ch_address_in(ch_address_in), .ch_wdata_in(ch_wdata_in),
      .ch_read_in(ch_read_in), .ch_write_in(ch_write_in),
      .ch_resp_out(rr_resp), .ch_rdata_out(rr_rdata),
      .s_address_out(rr_addr), .s_wdata_out(rr_wdata),
      .s_read_out(rr_rd), .s_write_out(rr_wr),
      .s_rdata_in(s_rdata_in), .s_resp_in(s_resp_in),
      .grant_out(rr_grant), .busy_out(rr_busy), .state_out(rr_state)
   );

   cache_arbiter_n #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .ch_address_in(ch_address_in), .ch_wdata_in(ch_wdata_in),
      .ch_read_in(ch_read_in), .ch_write_in(ch_write_in),
      .ch_resp_out(fp_resp), .ch_rdata_out(fp_rdata),
      .s_address_out(fp_addr), .s_wdata_out(fp_wdata),
      .s_read_out(fp_rd), .s_write_out(fp_wr),
      .s_rdata_in(s_rdata_in), .s_resp_in(s_resp_in),
      .grant_out(fp_grant), .busy_out(fp_busy), .state_out(fp_state)
   );

   task automatic chk(input string nm, input int vi, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL v%0d %s: got %h expected %h", vi, nm, act, exp);
      end
   endtask

   task automatic addv(input logic r, input logic [NCH-1:0] rd, input logic [NCH-1:0] wr,
                       input logic resp, input logic [1:0] st,
                       input logic [NCH-1:0] grr, input logic [NCH-1:0] gfp);
      vec_t v;
      v.rst = r; v.rd = rd; v.wr = wr; v.resp = resp; v.st = st; v.g_rr = grr; v.g_fp = gfp;
      vq.push_back(v);
   endtask

   function automatic int oh2idx(input logic [NCH-1:0] oh);
      int r = 0;
      for (int i = 0; i < NCH; i++) if (oh[i]) r = i;
      return r;
   endfunction

   // Expected L2-side values follow from the table's state and grant columns.
   task automatic check_vec(input int vi, input vec_t v);
      int gi;
      int gf;
      logic [NCH-1:0] er_rr, er_fp;
      gi = oh2idx(v.g_rr);
      gf = oh2idx(v.g_fp);
      er_rr = (v.st == A && v.resp) ? v.g_rr : '0;
      er_fp = (v.st == A && v.resp) ? v.g_fp : '0;
      chk("rr_state", vi, DW'(rr_state), DW'(v.st));
      chk("fp_state", vi, DW'(fp_state), DW'(v.st));
      chk("rr_grant", vi, DW'(rr_grant), DW'(v.g_rr));
      chk("fp_grant", vi, DW'(fp_grant), DW'(v.g_fp));
      chk("busy", vi, DW'(rr_busy), DW'(v.st != I));
      chk("s_address", vi, DW'(rr_addr), DW'((v.st == I) ? '0 : addr_tab[gi]));
      chk("fp_s_address", vi, DW'(fp_addr), DW'((v.st == I) ? '0 : addr_tab[gf]));
      chk("s_wdata", vi, rr_wdata, (v.st == I) ? '0 : wd_tab[gi]);
      chk("s_read", vi, DW'(rr_rd), DW'((v.st == A) ? v.rd[gi] : 1'b0));
      chk("s_write", vi, DW'(rr_wr), DW'((v.st == A) ? v.wr[gi] : 1'b0));
      chk("rr_ch_resp", vi, DW'(rr_resp), DW'(er_rr));
      chk("fp_ch_resp", vi, DW'(fp_resp), DW'(er_fp));
      chk("ch_rdata", vi, rr_rdata, s_rdata_in);
   endtask

   initial begin
      addr_tab[0] = 16'h0A00; addr_tab[1] = 16'h1234; addr_tab[2] = 16'h2B2B;
      wd_tab[0] = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
      wd_tab[1] = {4{32'h1111_1111}};
      wd_tab[2] = {4{32'h2222_2222}};
      for (int i = 0; i < NCH; i++) begin
         ch_address_in[i*AW +: AW] = addr_tab[i];
         ch_wdata_in[i*DW +: DW]   = wd_tab[i];
      end

      // reset, then single read on ch1
      addv(1, 3'b000, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b010, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b010, 3'b000, 0, S, 3'b010, 3'b010);
      addv(0, 3'b010, 3'b000, 0, A, 3'b010, 3'b010);
      addv(0, 3'b010, 3'b000, 0, A, 3'b010, 3'b010);
      addv(0, 3'b010, 3'b000, 0, A, 3'b010, 3'b010);
      addv(0, 3'b010, 3'b000, 1, A, 3'b010, 3'b010);
      addv(0, 3'b000, 3'b000, 0, I, 3'b000, 3'b000);
      // reset again so round-robin starts at ch0; all channels requesting
      addv(1, 3'b000, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b111, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b111, 3'b000, 0, S, 3'b001, 3'b001);
      addv(0, 3'b111, 3'b000, 0, A, 3'b001, 3'b001);
      addv(0, 3'b111, 3'b000, 1, A, 3'b001, 3'b001);
      addv(0, 3'b111, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b111, 3'b000, 0, S, 3'b010, 3'b001);
      addv(0, 3'b111, 3'b000, 1, A, 3'b010, 3'b001);
      addv(0, 3'b111, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b111, 3'b000, 0, S, 3'b100, 3'b001);
      addv(0, 3'b111, 3'b000, 1, A, 3'b100, 3'b001);
      addv(0, 3'b111, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b111, 3'b000, 0, S, 3'b001, 3'b001);
      addv(0, 3'b111, 3'b000, 1, A, 3'b001, 3'b001);
      addv(0, 3'b111, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b111, 3'b000, 0, S, 3'b010, 3'b001);
      addv(0, 3'b111, 3'b000, 1, A, 3'b010, 3'b001);
      addv(0, 3'b000, 3'b000, 0, I, 3'b000, 3'b000);
      // ch0 and ch2 requesting, then ch0 drops
      addv(0, 3'b101, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b101, 3'b000, 0, S, 3'b100, 3'b001);
      addv(0, 3'b101, 3'b000, 1, A, 3'b100, 3'b001);
      addv(0, 3'b101, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b101, 3'b000, 0, S, 3'b001, 3'b001);
      addv(0, 3'b101, 3'b000, 1, A, 3'b001, 3'b001);
      addv(0, 3'b100, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b100, 3'b000, 0, S, 3'b100, 3'b100);
      addv(0, 3'b100, 3'b000, 1, A, 3'b100, 3'b100);
      addv(0, 3'b000, 3'b000, 0, I, 3'b000, 3'b000);
      // ch0 write; ch1 read arrives during ACTIVE and waits
      addv(0, 3'b000, 3'b001, 0, I, 3'b000, 3'b000);
      addv(0, 3'b000, 3'b001, 0, S, 3'b001, 3'b001);
      addv(0, 3'b000, 3'b001, 0, A, 3'b001, 3'b001);
      addv(0, 3'b010, 3'b001, 0, A, 3'b001, 3'b001);
      addv(0, 3'b010, 3'b001, 1, A, 3'b001, 3'b001);
      addv(0, 3'b010, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b010, 3'b000, 0, S, 3'b010, 3'b010);
      addv(0, 3'b010, 3'b000, 0, A, 3'b010, 3'b010);
      // reset mid-ACTIVE; round-robin pointer returns to favour ch0
      addv(1, 3'b010, 3'b000, 0, I, 3'b000, 3'b000);
      addv(1, 3'b011, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b011, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b011, 3'b000, 0, S, 3'b001, 3'b001);
      addv(0, 3'b011, 3'b000, 0, A, 3'b001, 3'b001);
      addv(0, 3'b011, 3'b000, 1, A, 3'b001, 3'b001);
      addv(0, 3'b010, 3'b000, 0, I, 3'b000, 3'b000);
      addv(0, 3'b010, 3'b000, 0, S, 3'b010, 3'b010);
      addv(0, 3'b010, 3'b000, 1, A, 3'b010, 3'b010);
      addv(0, 3'b000, 3'b000, 0, I, 3'b000, 3'b000);
      // stray responses in IDLE and SETTLE are ignored
      addv(0, 3'b000, 3'b000, 1, I, 3'b000, 3'b000);
      addv(0, 3'b100, 3'b000, 1, I, 3'b000, 3'b000);
      addv(0, 3'b100, 3'b000, 1, S, 3'b100, 3'b100);
      addv(0, 3'b100, 3'b000, 0, A, 3'b100, 3'b100);
      addv(0, 3'b100, 3'b000, 1, A, 3'b100, 3'b100);
      addv(0, 3'b000, 3'b000, 0, I, 3'b000, 3'b000);
      // read and write together on one channel pass through unchanged
      addv(0, 3'b001, 3'b001, 0, I, 3'b000, 3'b000);
      addv(0, 3'b001, 3'b001, 0, S, 3'b001, 3'b001);
      addv(0, 3'b001, 3'b001, 0, A, 3'b001, 3'b001);
      addv(0, 3'b001, 3'b001, 1, A, 3'b001, 3'b001);
      addv(0, 3'b000, 3'b000, 0, I, 3'b000, 3'b000);

      for (int vi = 0; vi < vq.size(); vi++) begin
         @(negedge clk);
         rst_n       = ~vq[vi].rst;
         ch_read_in  = vq[vi].rd;
         ch_write_in = vq[vi].wr;
         s_resp_in   = vq[vi].resp;
         s_rdata_in  = {$urandom, $urandom, $urandom, $urandom};
         #1;
         check_vec(vi, vq[vi]);
         n_vec++;
      end

      // Short reset pulse inside the low clock phase while ACTIVE; last favours ch1 beforehand.
      @(negedge clk);
      ch_read_in = 3'b011; ch_write_in = '0; s_resp_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("pre_rst_state", 1000, DW'(rr_state), DW'(A));
      chk("pre_rst_grant", 1000, DW'(rr_grant), DW'(3'b010));
      chk("pre_rst_s_read", 1000, DW'(rr_rd), DW'(1'b1));
      chk("pre_rst_s_address", 1000, DW'(rr_addr), DW'(16'h1234));
      n_vec++;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", 1001, DW'(rr_state), DW'(I));
      chk("async_rst_grant", 1001, DW'(rr_grant), DW'(3'b000));
      chk("async_rst_s_read", 1001, DW'(rr_rd), DW'(1'b0));
      chk("async_rst_s_address", 1001, DW'(rr_addr), DW'(16'h0000));
      chk("async_rst_busy", 1001, DW'(rr_busy), DW'(1'b0));
      chk("async_rst_fp_grant", 1001, DW'(fp_grant), DW'(3'b000));
      n_vec++;
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_state", 1002, DW'(rr_state), DW'(S));
      chk("post_rst_grant", 1002, DW'(rr_grant), DW'(3'b001));
      chk("post_rst_s_read", 1002, DW'(rr_rd), DW'(1'b0));
      n_vec++;
      @(negedge clk);
      s_resp_in = 1'b1;
      #1;
      chk("post_rst_resp", 1003, DW'(rr_resp), DW'(3'b001));
      chk("post_rst_s_read", 1003, DW'(rr_rd), DW'(1'b1));
      n_vec++;
      @(negedge clk);
      s_resp_in = 1'b0; ch_read_in = '0;
      #1;
      chk("post_rst_idle", 1004, DW'(rr_state), DW'(I));
      chk("post_rst_resp_clear", 1004, DW'(rr_resp), DW'(3'b000));
      n_vec++;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
